// File: rtl/fp_mult_seq.sv
// fp_mult_seq: sequential IEEE-754 single-precision multiplier.
// An iterative shift-add mantissa datapath retires BITS_PER_CYCLE multiplier
// bits per cycle. Operands and results use valid/ready handshakes.
// Optional feature macro: FP_MULT_RNE_EN (defined: round-to-nearest-even,
// undefined: truncate toward zero). Latency is the same in both builds.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready is high only in IDLE. out_valid and res are
// registered and hold steady until out_ready is seen. An input presented in
// the same cycle as an output handshake is not accepted, because the FSM is
// still in DONE for that cycle.
module fp_mult_seq #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] opr1,
   input  logic [31:0] opr2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] res,
   output logic [2:0]  dbg_state
);

   localparam int B = BITS_PER_CYCLE;
   localparam int N = 24 / BITS_PER_CYCLE;

`ifdef FP_MULT_RNE_EN
   localparam logic RNE_EN = 1'b1;
`else
   localparam logic RNE_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_MULT   = 3'd2,
      S_NORM   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t state, state_nx;

   // Latched operands and working datapath registers.
   logic [31:0]        op1, op2;
   logic               sign;
   logic signed [9:0]  exp_sum;
   logic [47:0]        m1_sh;
   logic [23:0]        m2_sh;
   logic [47:0]        product;
   logic [4:0]         cnt;

   // Operand classification (driven from the latched operands).
   logic [7:0]         e1, e2;
   logic [22:0]        f1, f2;
   logic               nan1, nan2, inf1, inf2, zero1, zero2;
   logic               is_special;
   logic [31:0]        special_res;
   logic signed [9:0]  exp_calc;

   // Multiply step.
   logic [47:0]        chunk;
   logic [47:0]        partial;

   // Normalisation and rounding.
   logic [22:0]        mant_raw;
   logic               guard, sticky, round_up;
   logic [23:0]        mant_sum;
   logic [22:0]        mant_f;
   logic signed [9:0]  exp_n, exp_f;
   logic [31:0]        norm_res;

   assign in_ready  = (state == S_IDLE);
   assign dbg_state = state;

   // Classify operands and resolve special cases in priority order.
   always_comb begin
      e1 = op1[30:23];
      e2 = op2[30:23];
      f1 = op1[22:0];
      f2 = op2[22:0];
      nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
      nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
      inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
      inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
      // Exponent zero covers denormals too; they are flushed to zero.
      zero1 = (e1 == 8'h00);
      zero2 = (e2 == 8'h00);
      exp_calc = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
      is_special  = 1'b1;
      special_res = 32'h7FC0_0000;
      if (nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1)) begin
         special_res = 32'h7FC0_0000;
      end else if (inf1 || inf2) begin
         special_res = {op1[31] ^ op2[31], 8'hFF, 23'd0};
      end else if (zero1 || zero2) begin
         special_res = {op1[31] ^ op2[31], 31'd0};
      end else begin
         is_special = 1'b0;
      end
   end

   // One shift-add step: multiplicand times the next multiplier chunk.
   always_comb begin
      chunk        = '0;
      chunk[B-1:0] = m2_sh[B-1:0];
      partial      = m1_sh * chunk;
   end

   // Normalise the 48-bit product, round, and check the exponent range.
   always_comb begin
      if (product[47]) begin
         mant_raw = product[46:24];
         guard    = product[23];
         sticky   = |product[22:0];
         exp_n    = exp_sum + 10'sd1;
      end else begin
         mant_raw = product[45:23];
         guard    = product[22];
         sticky   = |product[21:0];
         exp_n    = exp_sum;
      end
      round_up = RNE_EN & guard & (sticky | mant_raw[0]);
      mant_sum = {1'b0, mant_raw} + {23'd0, round_up};
      // A carry out of the rounded mantissa means 1.111..1 rolled to 10.0.
      if (mant_sum[23]) begin
         exp_f  = exp_n + 10'sd1;
         mant_f = 23'd0;
      end else begin
         exp_f  = exp_n;
         mant_f = mant_sum[22:0];
      end
      if (exp_f >= 10'sd255) begin
         norm_res = {sign, 8'hFF, 23'd0};
      end else if (exp_f <= 10'sd0) begin
         norm_res = {sign, 31'd0};
      end else begin
         norm_res = {sign, exp_f[7:0], mant_f};
      end
   end

   // Next-state logic for the control FSM.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (in_valid) state_nx = S_UNPACK;
         S_UNPACK: state_nx = is_special ? S_DONE : S_MULT;
         S_MULT:   if (cnt == 5'(N - 1)) state_nx = S_NORM;
         S_NORM:   state_nx = S_DONE;
         S_DONE:   if (out_ready) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath registers and the registered output handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op1       <= '0;
         op2       <= '0;
         sign      <= 1'b0;
         exp_sum   <= '0;
         m1_sh     <= '0;
         m2_sh     <= '0;
         product   <= '0;
         cnt       <= '0;
         res       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_nx == S_DONE);
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op1     <= opr1;
                  op2     <= opr2;
                  product <= '0;
                  cnt     <= '0;
               end
            end
            S_UNPACK: begin
               sign    <= op1[31] ^ op2[31];
               exp_sum <= exp_calc;
               m1_sh   <= {24'd0, 1'b1, f1};
               m2_sh   <= {1'b1, f2};
               if (is_special) res <= special_res;
            end
            S_MULT: begin
               product <= product + partial;
               m1_sh   <= m1_sh << B;
               m2_sh   <= m2_sh >> B;
               cnt     <= cnt + 5'd1;
            end
            S_NORM: begin
               res <= norm_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mult_seq.sv
// tb_fp_mult_seq: directed vectors for fp_mult_seq, built with BITS_PER_CYCLE=1
// (dut0, latency 26) and BITS_PER_CYCLE=8 (dut1, latency 5). The rounding
// vector's expected value follows FP_MULT_RNE_EN.
module tb_fp_mult_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  in_valid, in_ready, out_valid, out_ready;
   logic [31:0] opr1 [2];
   logic [31:0] opr2 [2];
   logic [31:0] res  [2];
   logic [2:0]  dbg0, dbg1;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

`ifdef FP_MULT_RNE_EN
   localparam logic [31:0] ROUND_EXP = 32'h3FC0_0002;
`else
   localparam logic [31:0] ROUND_EXP = 32'h3FC0_0001;
`endif

   // Clock and reset.
   always #5 clk = ~clk;

   fp_mult_seq #(.BITS_PER_CYCLE(1)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .opr1(opr1[0]), .opr2(opr2[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .res(res[0]), .dbg_state(dbg0)
   );

   fp_mult_seq #(.BITS_PER_CYCLE(8)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .opr1(opr1[1]), .opr2(opr2[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .res(res[1]), .dbg_state(dbg1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Driver: one full transaction with latency, backpressure and handshake checks.
   task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want_res, input int want_lat, input string tag);
      int lat;
      int hold;
      logic [31:0] want;
      logic [31:0] held;
      check({tag, " in_ready"}, 32'(in_ready[s]), 32'd1);
      opr1[s] = a;
      opr2[s] = b;
      in_valid[s] = 1'b1;
      exp_q.push_back(want_res);
      tick();
      in_valid[s] = 1'b0;
      opr1[s] = $urandom;
      opr2[s] = $urandom;
      lat = 0;
      while (!out_valid[s] && lat < 200) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(want_lat));
      want = exp_q.pop_front();
      check({tag, " res"}, res[s], want);
      held = res[s];
      hold = $urandom_range(1, 3);
      repeat (hold) tick();
      check({tag, " held out_valid"}, 32'(out_valid[s]), 32'd1);
      check({tag, " held res"}, res[s], held);
      // Output handshake with a competing input that must be ignored.
      out_ready[s] = 1'b1;
      in_valid[s]  = 1'b1;
      opr1[s] = 32'h4000_0000;
      opr2[s] = 32'h4000_0000;
      tick();
      out_ready[s] = 1'b0;
      in_valid[s]  = 1'b0;
      check({tag, " out_valid cleared"}, 32'(out_valid[s]), 32'd0);
      check({tag, " input not taken"}, 32'(in_ready[s]), 32'd1);
   endtask

   initial begin
      bit stayed_low;
      in_valid  = '0;
      out_ready = '0;
      for (int i = 0; i < 2; i++) begin
         opr1[i] = '0;
         opr2[i] = '0;
      end
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset in_ready%0d", i), 32'(in_ready[i]), 32'd1);
         check($sformatf("reset out_valid%0d", i), 32'(out_valid[i]), 32'd0);
         check($sformatf("reset res%0d", i), res[i], 32'd0);
      end

      // Normal products, BITS_PER_CYCLE=1.
      run_op(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 26, "b1 2x3");
      run_op(0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 26, "b1 1.5sq");
      run_op(0, 32'hC000_0000, 32'h3F80_0000, 32'hC000_0000, 26, "b1 sign");
      run_op(0, 32'h3F80_0001, 32'h3FC0_0000, ROUND_EXP,     26, "b1 round");

      // Specials resolve in one cycle.
      run_op(0, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1, "inf x 0");
      run_op(0, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1, "nan");
      run_op(0, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1, "-inf");
      run_op(0, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1, "-zero");

      // Range limits.
      run_op(0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 26, "overflow");
      run_op(0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 26, "underflow");
      run_op(0, 32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1,  "denormal");

      // Reset in the middle of an operation.
      opr1[0] = 32'h4000_0000;
      opr2[0] = 32'h4040_0000;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      check("mid reset out_valid", 32'(out_valid[0]), 32'd0);
      rst_n = 1'b1;
      check("after release in_ready", 32'(in_ready[0]), 32'd1);
      stayed_low = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (out_valid[0]) stayed_low = 1'b0;
      end
      check("aborted op silent", 32'(stayed_low), 32'd1);
      run_op(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 26, "post reset");

      // Same normal vectors, BITS_PER_CYCLE=8.
      run_op(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5, "b8 2x3");
      run_op(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 5, "b8 1.5sq");
      run_op(1, 32'hC000_0000, 32'h3F80_0000, 32'hC000_0000, 5, "b8 sign");
      run_op(1, 32'h3F80_0001, 32'h3FC0_0000, ROUND_EXP,     5, "b8 round");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
